// File: rtl/div_pkg.sv
// Shared types and default widths for the sequential restoring divider.
package div_pkg;

    localparam int DEF_DIVIDEND_W = 8;
    localparam int DEF_DIVISOR_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_restore_step.sv
// One radix-2 restoring iteration: shift in a dividend bit, trial-subtract, restore on borrow.
module div_restore_step #(
    parameter int DIVISOR_W = 4
) (
    input  logic [DIVISOR_W:0]   rem_in,
    input  logic                 dividend_bit,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W:0]   rem_out,
    output logic                 q_bit
);

    logic [DIVISOR_W:0]   trial;
    logic [DIVISOR_W+1:0] diff;

    // A restored remainder always fits DIVISOR_W bits, so the incoming top bit carries no information.
    logic unused_rem_msb;
    assign unused_rem_msb = rem_in[DIVISOR_W];

    always_comb begin
        trial   = {rem_in[DIVISOR_W-1:0], dividend_bit};
        diff    = {1'b0, trial} - {2'b00, divisor};
        q_bit   = ~diff[DIVISOR_W+1];
        rem_out = q_bit ? diff[DIVISOR_W:0] : trial;
    end

endmodule

// File: rtl/div_8x4_seq.sv
// Sequential radix-2 restoring divider: one quotient bit per clock behind a start/busy/done handshake.
module div_8x4_seq
    import div_pkg::*;
#(
    parameter int DIVIDEND_W = DEF_DIVIDEND_W,
    parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int CNT_W = $clog2(DIVIDEND_W);
    localparam int REM_W = DIVISOR_W + 1;

    state_t                state, state_nxt;
    logic [REM_W-1:0]      r, rem_nxt;
    logic [DIVIDEND_W-1:0] q;
    logic [CNT_W-1:0]      count;
    logic [DIVISOR_W-1:0]  div_q;
    logic                  q_bit;
    logic                  accept;
    logic                  last;

    assign accept = start && (state != RUN);
    assign last   = (state == RUN) && (count == CNT_W'(DIVIDEND_W - 1));

    div_restore_step #(.DIVISOR_W(DIVISOR_W)) u_step (
        .rem_in       (r),
        .dividend_bit (q[DIVIDEND_W-1]),
        .divisor      (div_q),
        .rem_out      (rem_nxt),
        .q_bit        (q_bit)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: default assignment first keeps this purely combinational (no inferred latch).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (start) state_nxt = (divisor == '0) ? DONE : RUN;
                else       state_nxt = IDLE;
            end
            RUN:     if (last) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // Results are written only on an accepting zero-divisor edge or the final iteration edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r           <= '0;
            q           <= '0;
            count       <= '0;
            div_q       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            if (divisor == '0) begin
                quotient    <= '1;
                remainder   <= '0;
                div_by_zero <= 1'b1;
            end else begin
                div_q <= divisor;
                r     <= '0;
                q     <= dividend;
                count <= '0;
            end
        end else if (state == RUN) begin
            r     <= rem_nxt;
            q     <= {q[DIVIDEND_W-2:0], q_bit};
            count <= count + 1'b1;
            if (last) begin
                quotient    <= {q[DIVIDEND_W-2:0], q_bit};
                remainder   <= rem_nxt[DIVISOR_W-1:0];
                div_by_zero <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_div_8x4_seq.sv
// Directed and exhaustive checks for the sequential 8/4 restoring divider.
module tb_div_8x4_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    div_8x4_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // Pulses start for one edge, scrambles the operands afterwards, then counts edges until done.
    task automatic run_op(input logic [7:0] dd, input logic [3:0] dv, output int lat, output int bcnt);
        dividend = dd;
        divisor  = dv;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        dividend = 8'($urandom);
        divisor  = 4'($urandom);
        lat  = 0;
        bcnt = 0;
        while (!done && lat < 20) begin
            if (busy) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
        if (!done) lat = 99;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; dividend = 8'd0; divisor = 4'd0;
        #12;
        n_vec++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 15'd0) begin
            n_bad++;
            $display("FAIL reset: got busy=%b done=%b q=%0d r=%0d z=%b, want all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int lat, bcnt;
        run_op(8'd200, 4'd7, lat, bcnt);
        n_vec++;
        if ({quotient, remainder, div_by_zero} !== {8'd28, 4'd4, 1'b0} || lat != 8 || bcnt != 8) begin
            n_bad++;
            $display("FAIL basic 200/7: got q=%0d r=%0d z=%b lat=%0d busy=%0d, want q=28 r=4 z=0 lat=8 busy=8",
                     quotient, remainder, div_by_zero, lat, bcnt);
        end
        @(posedge clk); #1;
        n_vec++;
        if ({done, busy, quotient, remainder, div_by_zero} !== {1'b0, 1'b0, 8'd28, 4'd4, 1'b0}) begin
            n_bad++;
            $display("FAIL done_pulse: got done=%b busy=%b q=%0d r=%0d z=%b, want done=0 busy=0 held 28/4/0",
                     done, busy, quotient, remainder, div_by_zero);
        end
    endtask

    task automatic test_vectors();
        logic [7:0] v_dd [4] = '{8'd255, 8'd5,  8'd255, 8'h3C};
        logic [3:0] v_dv [4] = '{4'd1,   4'd9,  4'd15,  4'd0};
        logic [7:0] v_q  [4] = '{8'd255, 8'd0,  8'd17,  8'hFF};
        logic [3:0] v_r  [4] = '{4'd0,   4'd5,  4'd0,   4'd0};
        logic       v_z  [4] = '{1'b0,   1'b0,  1'b0,   1'b1};
        int         v_l  [4] = '{8,      8,     8,      0};
        int lat, bcnt;
        for (int i = 0; i < 4; i++) begin
            run_op(v_dd[i], v_dv[i], lat, bcnt);
            n_vec++;
            if ({quotient, remainder, div_by_zero} !== {v_q[i], v_r[i], v_z[i]} || lat != v_l[i] || bcnt != v_l[i]) begin
                n_bad++;
                $display("FAIL vec %0d/%0d: got q=%0d r=%0d z=%b lat=%0d busy=%0d, want q=%0d r=%0d z=%b lat=%0d busy=%0d",
                         v_dd[i], v_dv[i], quotient, remainder, div_by_zero, lat, bcnt,
                         v_q[i], v_r[i], v_z[i], v_l[i], v_l[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        dividend = 8'd100; divisor = 4'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (!done && lat < 20) begin
            start = (lat == 2);
            if (lat == 2) begin dividend = 8'd50; divisor = 4'd5; end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        n_vec++;
        if (!done || {quotient, remainder, div_by_zero} !== {8'd33, 4'd1, 1'b0} || lat != 8) begin
            n_bad++;
            $display("FAIL busy_ignore 100/3: got done=%b q=%0d r=%0d z=%b lat=%0d, want done=1 q=33 r=1 z=0 lat=8",
                     done, quotient, remainder, div_by_zero, lat);
        end
        // Start issued in the DONE cycle is accepted immediately.
        dividend = 8'd50; divisor = 4'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_vec++;
        if ({busy, done, quotient, remainder} !== {1'b1, 1'b0, 8'd33, 4'd1}) begin
            n_bad++;
            $display("FAIL accept_in_done: got busy=%b done=%b q=%0d r=%0d, want busy=1 done=0 held 33/1",
                     busy, done, quotient, remainder);
        end
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        n_vec++;
        if (!done || {quotient, remainder, div_by_zero} !== {8'd10, 4'd0, 1'b0} || lat != 8) begin
            n_bad++;
            $display("FAIL back_to_back 50/5: got done=%b q=%0d r=%0d z=%b lat=%0d, want done=1 q=10 r=0 z=0 lat=8",
                     done, quotient, remainder, div_by_zero, lat);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_abort();
        int lat, bcnt, seen;
        dividend = 8'd200; divisor = 4'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 15'd0) begin
            n_bad++;
            $display("FAIL async_abort: got busy=%b done=%b q=%0d r=%0d z=%b, want all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        @(negedge clk); rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        n_vec++;
        if (seen != 0) begin
            n_bad++;
            $display("FAIL no_done_after_abort: got %0d busy/done cycles, want 0", seen);
        end
        run_op(8'd9, 4'd2, lat, bcnt);
        n_vec++;
        if ({quotient, remainder, div_by_zero} !== {8'd4, 4'd1, 1'b0} || lat != 8) begin
            n_bad++;
            $display("FAIL post_reset 9/2: got q=%0d r=%0d z=%b lat=%0d, want q=4 r=1 z=0 lat=8",
                     quotient, remainder, div_by_zero, lat);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_sweep();
        int lat, bcnt, exp_lat;
        logic [7:0] eq;
        logic [3:0] er;
        logic       ez;
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_op(8'(a), 4'(b), lat, bcnt);
                if (b == 0) begin
                    eq = 8'hFF; er = 4'd0; ez = 1'b1; exp_lat = 0;
                end else begin
                    eq = 8'(a / b); er = 4'(a % b); ez = 1'b0; exp_lat = 8;
                end
                n_vec++;
                if ({quotient, remainder, div_by_zero} !== {eq, er, ez} || lat != exp_lat || bcnt != exp_lat) begin
                    n_bad++;
                    $display("FAIL sweep %0d/%0d: got q=%0d r=%0d z=%b lat=%0d busy=%0d, want q=%0d r=%0d z=%b lat=%0d",
                             a, b, quotient, remainder, div_by_zero, lat, bcnt, eq, er, ez, exp_lat);
                end
                if (b != 0) begin
                    n_vec++;
                    if (int'(quotient) * b + int'(remainder) != a || int'(remainder) >= b) begin
                        n_bad++;
                        $display("FAIL invariant %0d/%0d: got q*d+r=%0d r=%0d, want %0d with r<%0d",
                                 a, b, int'(quotient) * b + int'(remainder), remainder, a, b);
                    end
                end
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_vectors();
        test_back_to_back();
        test_reset_abort();
        test_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
